// File: rtl/vga_scan_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen_pkg
//  Description : Shared raster-timing definitions for the VGA scan generator
//                and the drawing blocks that consume its counters. Holds the
//                default 640x480@60 timing, counter widths, and small helpers
//                for sizing counters and decoding sync windows.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_scan_gen_pkg;

    // Raster coordinate width; 800 columns and 525 lines both fit in 10 bits.
    localparam int unsigned CNT_W       = 10;
    // Frame-divider counter width (MOVE_DIV is limited to 1..255).
    localparam int unsigned FRAME_CNT_W = 8;

    typedef logic [CNT_W-1:0]       coord_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // Default 640x480@60 timing with a 25 MHz pixel rate.
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Width needed to hold 0..n-1; never less than one bit so that a
    // divide-by-one counter still has a legal (constant zero) register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when lo <= value < lo+len. Used for the active-low sync windows.
    function automatic logic in_window(
        input coord_t      value,
        input int unsigned lo,
        input int unsigned len
    );
        int unsigned v;
        v = {{(32-CNT_W){1'b0}}, value};
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage : vga_scan_gen_pkg
`default_nettype wire

// File: rtl/vga_scan_gen_modn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : modn_counter
//  Description : Enabled modulo-N counter. Counts 0..N-1 on each enabled
//                clock and wraps to 0. 'wrap' is a combinational flag that is
//                high in the enabled cycle where the count is at N-1, so it
//                can directly enable the next counter in a cascade.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   1   system clock
//    rst    in   1   synchronous active-high reset, count returns to 0
//    en     in   1   advance the count this cycle
//    count  out  W   current count, registered
//    wrap   out  1   en & (count == N-1)
// ============================================================================
module modn_counter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : modn_counter
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : VGA raster timing generator. Divides clk into a one-cycle
//                pixel enable, runs the horizontal/vertical raster counters,
//                decodes active-low syncs and blanking, and issues a
//                per-frame 'move' strobe for the ball/paddle drawing logic.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   1   system clock (100 MHz nominal)
//    rst        in   1   synchronous active-high reset
//    pause      in   1   suppress move strobes; raster keeps running
//    pixpulse   out  1   one-clk pixel enable, every PIX_DIV clks
//    hcount     out  10  current column, 0..H_TOTAL-1
//    vcount     out  10  current line, 0..V_TOTAL-1
//    hsync      out  1   active-low horizontal sync
//    vsync      out  1   active-low vertical sync
//    blank      out  1   high outside the visible area
//    move       out  1   one-pixel-period strobe, once per MOVE_DIV frames
//    frame_end  out  1   one-clk pulse on the last pixpulse of a frame
// ============================================================================
module vga_scan_gen
    import vga_scan_gen_pkg::*;
#(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned MOVE_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    output logic             pixpulse,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             move,
    output logic             frame_end
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;

    localparam int unsigned     PIX_W        = cnt_width(PIX_DIV);
    // pixpulse is registered, so it is set on the edge that moves the divider
    // onto its last count; that is the edge leaving PIX_DIV-2.
    localparam logic [PIX_W-1:0] PIX_PRE_LAST = PIX_W'(PIX_DIV - 2);
    localparam coord_t          MOVE_LINE    = CNT_W'(V_VISIBLE);

    // ------------------------------------------------------------------
    // Counter cascade: pixel divider -> column -> line -> frame divider.
    // Each stage advances on the previous stage's wrap flag.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_pixdiv;
    logic             w_pix_wrap;
    coord_t           w_hcount;
    logic             w_h_wrap;
    coord_t           w_vcount;
    logic             w_v_wrap;
    frame_cnt_t       w_frame_cnt;
    logic             w_unused_frame_wrap;

    modn_counter #(
        .N (PIX_DIV),
        .W (PIX_W)
    ) u_pixdiv (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (w_pixdiv),
        .wrap  (w_pix_wrap)
    );

    // w_pix_wrap is high exactly in the clk where pixpulse is high, so the
    // column counter advances on the pixpulse edge and the coordinates stay
    // stable across the whole pixel, including the pixpulse clk itself.
    modn_counter #(
        .N (H_TOTAL),
        .W (CNT_W)
    ) u_hcount (
        .clk   (clk),
        .rst   (rst),
        .en    (w_pix_wrap),
        .count (w_hcount),
        .wrap  (w_h_wrap)
    );

    modn_counter #(
        .N (V_TOTAL),
        .W (CNT_W)
    ) u_vcount (
        .clk   (clk),
        .rst   (rst),
        .en    (w_h_wrap),
        .count (w_vcount),
        .wrap  (w_v_wrap)
    );

    // Frame divider for the move cadence. It keeps counting while paused so
    // the strobe stays on the same frames once pause is released.
    modn_counter #(
        .N (MOVE_DIV),
        .W (FRAME_CNT_W)
    ) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_v_wrap),
        .count (w_frame_cnt),
        .wrap  (w_unused_frame_wrap)
    );

    // ------------------------------------------------------------------
    // Registered pixel enable and pause.
    // ------------------------------------------------------------------
    logic pixpulse_q;
    logic pixpulse_d;
    logic pause_q;
    logic pause_d;

    always_comb begin
        pixpulse_d = (w_pixdiv == PIX_PRE_LAST);
        pause_d    = pause;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixpulse_q <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            pixpulse_q <= pixpulse_d;
            pause_q    <= pause_d;
        end
    end

    // ------------------------------------------------------------------
    // Decodes from registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        hsync     = ~in_window(w_hcount, H_SYNC_START, H_SYNC);
        vsync     = ~in_window(w_vcount, V_SYNC_START, V_SYNC);
        blank     = ({22'd0, w_hcount} >= H_VISIBLE) || ({22'd0, w_vcount} >= V_VISIBLE);
        // First pixel of the first blank line: every visible pixel of the
        // frame has already been drawn, so moving objects here cannot tear.
        move      = (w_hcount == '0) && (w_vcount == MOVE_LINE)
                    && (w_frame_cnt == '0) && !pause_q;
        // Column and line both at their last value on the pixpulse clk.
        frame_end = w_v_wrap;
    end

    assign pixpulse = pixpulse_q;
    assign hcount   = w_hcount;
    assign vcount   = w_vcount;

endmodule : vga_scan_gen
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_gen
//  Description : Self-checking bench for vga_scan_gen. One full-size
//                640x480 instance plus two reduced-raster instances
//                (MOVE_DIV=1 and MOVE_DIV=3) so several whole frames fit in
//                a short run. Expected outputs come from a closed-form model
//                of the elapsed clock count since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_gen;

    // Reduced raster: 24 x 15, 360 pixels / 1440 clks per frame.
    localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 2;
    localparam int S_VV = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME_CLKS = 4 * 24 * 15;
    localparam int MID_RST_K    = 10600;   // small raster frame 7 at (10,5)
    localparam int TAIL_CLKS    = 2900;
    localparam int CYCLE_CAP    = 20000;

    typedef struct {
        int pixpulse;
        int hcount;
        int vcount;
        int hsync;
        int vsync;
        int blank;
        int move;
        int frame_end;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pause;

    always #5 clk = ~clk;

    logic       f_pp, f_hs, f_vs, f_bl, f_mv, f_fe;
    logic [9:0] f_h, f_v;
    logic       a_pp, a_hs, a_vs, a_bl, a_mv, a_fe;
    logic [9:0] a_h, a_v;
    logic       b_pp, b_hs, b_vs, b_bl, b_mv, b_fe;
    logic [9:0] b_h, b_v;

    vga_scan_gen u_full (
        .clk(clk), .rst(rst), .pause(pause),
        .pixpulse(f_pp), .hcount(f_h), .vcount(f_v),
        .hsync(f_hs), .vsync(f_vs), .blank(f_bl), .move(f_mv), .frame_end(f_fe)
    );

    vga_scan_gen #(
        .PIX_DIV(4), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .MOVE_DIV(1)
    ) u_small1 (
        .clk(clk), .rst(rst), .pause(pause),
        .pixpulse(a_pp), .hcount(a_h), .vcount(a_v),
        .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .move(a_mv), .frame_end(a_fe)
    );

    vga_scan_gen #(
        .PIX_DIV(4), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .MOVE_DIV(3)
    ) u_small3 (
        .clk(clk), .rst(rst), .pause(pause),
        .pixpulse(b_pp), .hcount(b_h), .vcount(b_v),
        .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .move(b_mv), .frame_end(b_fe)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // State after k clk edges since the last reset edge, pq = registered pause.
    function automatic exp_t model(input int k, input bit pq, input int hv, input int hf,
                                   input int hs, input int hb, input int vv, input int vf,
                                   input int vs, input int vb, input int md);
        exp_t e;
        int ht, vt, pix, line, h, v, fr;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        pix  = k / 4;
        line = pix / ht;
        h    = pix % ht;
        v    = line % vt;
        fr   = line / vt;
        e.pixpulse  = ((k % 4) == 3) ? 1 : 0;
        e.hcount    = h;
        e.vcount    = v;
        e.hsync     = (h >= hv + hf && h < hv + hf + hs) ? 0 : 1;
        e.vsync     = (v >= vv + vf && v < vv + vf + vs) ? 0 : 1;
        e.blank     = (h >= hv || v >= vv) ? 1 : 0;
        e.move      = (h == 0 && v == vv && (fr % md) == 0 && !pq) ? 1 : 0;
        e.frame_end = (e.pixpulse == 1 && h == ht - 1 && v == vt - 1) ? 1 : 0;
        return e;
    endfunction

    task automatic compare(input string name, input int k, input exp_t e,
                           input logic pp, input logic [9:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic bl,
                           input logic mv, input logic fe);
        check($sformatf("%s.pixpulse@k%0d", name, k),  {31'd0, pp}, e.pixpulse);
        check($sformatf("%s.hcount@k%0d", name, k),    {22'd0, h},  e.hcount);
        check($sformatf("%s.vcount@k%0d", name, k),    {22'd0, v},  e.vcount);
        check($sformatf("%s.hsync@k%0d", name, k),     {31'd0, hs}, e.hsync);
        check($sformatf("%s.vsync@k%0d", name, k),     {31'd0, vs}, e.vsync);
        check($sformatf("%s.blank@k%0d", name, k),     {31'd0, bl}, e.blank);
        check($sformatf("%s.move@k%0d", name, k),      {31'd0, mv}, e.move);
        check($sformatf("%s.frame_end@k%0d", name, k), {31'd0, fe}, e.frame_end);
    endtask

    exp_t q_full[$];
    exp_t q_s1[$];
    exp_t q_s3[$];

    initial begin
        int   k, k_next, phase, cyc;
        bit   pq_next, done;
        exp_t e;
        int   adj_pp, hs_low_line0, h_wraps;
        int   fe_s1, fe_s3, mv_s1, mv_s3, mv_hi_s1;
        logic prev_f_pp, prev_a_pp, prev_b_pp;
        logic [9:0] prev_f_h, prev_f_v;

        rst = 1'b1; pause = 1'b0;
        k = 0; phase = 0; done = 1'b0;
        adj_pp = 0; hs_low_line0 = 0; h_wraps = 0;
        fe_s1 = 0; fe_s3 = 0; mv_s1 = 0; mv_s3 = 0; mv_hi_s1 = 0;
        prev_f_pp = 1'b0; prev_a_pp = 1'b0; prev_b_pp = 1'b0;
        prev_f_h = '0; prev_f_v = '0;

        for (cyc = 0; cyc < CYCLE_CAP && !done; cyc++) begin
            // Drive stimulus for the coming edge and queue what it should yield.
            rst   = (cyc < 3) || (phase == 0 && k == MID_RST_K);
            pause = (phase == 0 && k >= S_FRAME_CLKS - 40 && k < 2 * S_FRAME_CLKS);
            k_next  = rst ? 0 : k + 1;
            pq_next = rst ? 1'b0 : pause;
            q_full.push_back(model(k_next, pq_next, 640, 16, 96, 48, 480, 10, 2, 33, 1));
            q_s1.push_back(model(k_next, pq_next, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1));
            q_s3.push_back(model(k_next, pq_next, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 3));
            if (phase == 0 && cyc >= 3 && rst) phase = 1;

            @(posedge clk);
            #1;
            k = k_next;
            e = q_full.pop_front();
            compare("full", k, e, f_pp, f_h, f_v, f_hs, f_vs, f_bl, f_mv, f_fe);
            e = q_s1.pop_front();
            compare("s1", k, e, a_pp, a_h, a_v, a_hs, a_vs, a_bl, a_mv, a_fe);
            e = q_s3.pop_front();
            compare("s3", k, e, b_pp, b_h, b_v, b_hs, b_vs, b_bl, b_mv, b_fe);

            // Event tallies taken from the DUT outputs.
            if ((f_pp && prev_f_pp) || (a_pp && prev_a_pp) || (b_pp && prev_b_pp)) adj_pp++;
            if (phase == 0 && f_pp && f_v == 10'd0 && !f_hs) hs_low_line0++;
            if (phase == 0 && prev_f_h == 10'd799 && f_h == 10'd0) begin
                h_wraps++;
                check("full.vcount_step_on_hwrap", {22'd0, f_v}, {22'd0, prev_f_v} + 32'd1);
            end
            if (a_fe) fe_s1++;
            if (b_fe) fe_s3++;
            if (a_mv && a_pp) mv_s1++;
            if (b_mv && b_pp) mv_s3++;
            if (a_mv) mv_hi_s1++;
            prev_f_pp = f_pp; prev_a_pp = a_pp; prev_b_pp = b_pp;
            prev_f_h  = f_h;  prev_f_v  = f_v;

            if (phase == 1 && !rst && k >= TAIL_CLKS) done = 1'b1;
        end

        check("run_completed", {31'd0, done}, 32'd1);
        check("adjacent_pixpulse", adj_pp, 0);
        check("full.hsync_low_pixels_line0", hs_low_line0, 96);
        check("full.hcount_wraps", h_wraps, 3);
        check("s1.frame_end_count", fe_s1, 9);
        check("s3.frame_end_count", fe_s3, 9);
        check("s1.move_pixpulses", mv_s1, 8);
        check("s3.move_pixpulses", mv_s3, 4);
        check("s1.move_high_clks", mv_hi_s1, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_vga_scan_gen
`default_nettype wire
